// File: rtl/uart_fifo.sv
// uart_fifo: memory-mapped UART peripheral on the 8-bit I/O bus.
// It has RX/TX byte FIFOs, a programmable 16-bit baud divisor, sticky error flags
// and a registered level interrupt.
// Optional feature macro: UART_PARITY_EN
//   Defined:   the MODE register and parity bit generation and checking are built.
//   Undefined: MODE reads 8'h00 and parity_err stays 0.

// Byte FIFO with a power-of-two depth.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module uart_fifo_buf #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_rdata,
  output logic       o_empty,
  output logic       o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign o_rdata   = r_mem[r_rd_ptr];

  // Storage write; the array has no reset so that it can map onto RAM.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally at DEPTH; the occupancy count is one bit wider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module uart_fifo #(
  parameter logic [7:0]  BASE_ADDR  = 8'h0A,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd103,
  parameter int          OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic [7:0] address,
  input  logic       w_en,
  input  logic       r_en,
  output logic [7:0] dout,
  input  logic       rx,
  output logic       tx,
  output logic       irq
);
  localparam int            TW      = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TC_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TC_HALF = TW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  // Bus decode
  logic [7:0] w_off;
  logic       w_wr_ctrl, w_wr_data, w_wr_divl, w_wr_divh, w_rd_data;
  assign w_off     = address - BASE_ADDR;
  assign w_wr_ctrl = w_en & (w_off == 8'd0);
  assign w_wr_data = w_en & (w_off == 8'd1);
  assign w_wr_divl = w_en & (w_off == 8'd2);
  assign w_wr_divh = w_en & (w_off == 8'd3);
  assign w_rd_data = r_en & (w_off == 8'd1);

  logic [15:0] r_div, r_presc;
  logic        w_tick;
  logic        r_rx_s1, r_rx_s2, w_rx_s;
  logic        r_rx_ie, r_tx_ie, r_overrun, r_frame_err, r_parity_err;
  logic [7:0]  r_dout;
  logic        r_irq;
  logic        w_par_en, w_par_odd;
  logic [7:0]  w_mode, w_status;

  rx_state_t   r_rx_state, w_rx_state_next;
  logic [TW-1:0] r_rx_tcnt;
  logic [2:0]  r_rx_bcnt;
  logic [7:0]  r_rx_shift;
  logic        w_rx_bit_end, w_rx_can_push;
  logic        w_rx_push, w_set_overrun, w_set_frame, w_set_parity;

  tx_state_t   r_tx_state, w_tx_state_next;
  logic [TW-1:0] r_tx_tcnt;
  logic [2:0]  r_tx_bcnt;
  logic [7:0]  r_tx_shift;
  logic        r_tx_par;
  logic        w_tx_bit_end, w_tx_pop, w_tx, w_tx_idle;

  logic [7:0]  w_rx_rdata, w_tx_rdata;
  logic        w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;

  uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .i_push(w_rx_push), .i_pop(w_rd_data),
    .i_wdata(r_rx_shift), .o_rdata(w_rx_rdata), .o_empty(w_rx_empty), .o_full(w_rx_full)
  );

  uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .i_push(w_wr_data), .i_pop(w_tx_pop),
    .i_wdata(din), .o_rdata(w_tx_rdata), .o_empty(w_tx_empty), .o_full(w_tx_full)
  );

`ifdef UART_PARITY_EN
  logic r_par_en, r_par_odd;
  logic w_wr_mode;
  assign w_wr_mode = w_en & (w_off == 8'd4);
  // Parity mode register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_en  <= 1'b0;
      r_par_odd <= 1'b0;
    end else if (w_wr_mode) begin
      r_par_en  <= din[0];
      r_par_odd <= din[1];
    end
  end
  assign w_par_en  = r_par_en;
  assign w_par_odd = r_par_odd;
  assign w_mode    = {6'b0, r_par_odd, r_par_en};
`else
  assign w_par_en  = 1'b0;
  assign w_par_odd = 1'b0;
  assign w_mode    = 8'h00;
`endif

  assign w_rx_s        = r_rx_s2;
  assign w_tick        = (r_presc == r_div);
  assign w_tx_idle     = w_tx_empty & (r_tx_state == TX_IDLE);
  // A bus pop in the same cycle makes room for the received byte.
  assign w_rx_can_push = ~w_rx_full | (w_rd_data & ~w_rx_empty);
  assign w_status      = {r_tx_ie, r_rx_ie, r_parity_err, r_frame_err, r_overrun,
                          w_tx_idle, ~w_tx_full, ~w_rx_empty};

  // Divisor register and prescaler; any divisor write restarts the prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= DIV_RESET;
      r_presc <= '0;
    end else begin
      if (w_wr_divl) r_div[7:0]  <= din;
      if (w_wr_divh) r_div[15:8] <= din;
      if (w_wr_divl | w_wr_divh | w_tick) r_presc <= '0;
      else                                r_presc <= r_presc + 16'd1;
    end
  end

  // Two-flop synchronizer for the asynchronous serial input, idling high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  // Control bits and sticky flags; a hardware set beats a same-cycle write-1-to-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_ie      <= 1'b0;
      r_tx_ie      <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_rx_ie <= din[6];
        r_tx_ie <= din[7];
      end
      r_overrun    <= w_set_overrun | (r_overrun    & ~(w_wr_ctrl & din[3]));
      r_frame_err  <= w_set_frame   | (r_frame_err  & ~(w_wr_ctrl & din[4]));
      r_parity_err <= w_set_parity  | (r_parity_err & ~(w_wr_ctrl & din[5]));
    end
  end

  // Registered read data; unmapped offsets hold the previous value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= 8'h00;
    end else if (r_en) begin
      case (w_off)
        8'd0:    r_dout <= w_status;
        8'd1:    r_dout <= w_rx_empty ? 8'h00 : w_rx_rdata;
        8'd2:    r_dout <= r_div[7:0];
        8'd3:    r_dout <= r_div[15:8];
        8'd4:    r_dout <= w_mode;
        default: r_dout <= r_dout;
      endcase
    end
  end

  // Registered interrupt request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_irq <= 1'b0;
    else        r_irq <= (r_rx_ie & ~w_rx_empty) | (r_tx_ie & w_tx_idle) |
                         r_overrun | r_frame_err | r_parity_err;
  end

  assign dout = r_dout;
  assign irq  = r_irq;

  // RX FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rx_state <= RX_IDLE;
    else        r_rx_state <= w_rx_state_next;
  end

  // RX next state; the FSM only moves on a sample tick.
  always_comb begin
    w_rx_state_next = r_rx_state;
    if (w_tick) begin
      case (r_rx_state)
        RX_IDLE:   if (!w_rx_s) w_rx_state_next = RX_START;
        RX_START:  if (r_rx_tcnt == TC_HALF) w_rx_state_next = w_rx_s ? RX_IDLE : RX_DATA;
        RX_DATA:   if (r_rx_tcnt == TC_LAST && r_rx_bcnt == 3'd7)
                     w_rx_state_next = w_par_en ? RX_PARITY : RX_STOP;
        RX_PARITY: if (r_rx_tcnt == TC_LAST) w_rx_state_next = RX_STOP;
        RX_STOP:   if (r_rx_tcnt == TC_LAST) w_rx_state_next = w_rx_s ? RX_IDLE : RX_BREAK;
        RX_BREAK:  if (w_rx_s) w_rx_state_next = RX_IDLE;
        default:   w_rx_state_next = RX_IDLE;
      endcase
    end
  end

  // RX tick/bit counters and data shifter (LSB arrives first)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_tcnt  <= '0;
      r_rx_bcnt  <= 3'd0;
      r_rx_shift <= 8'h00;
    end else if (w_tick) begin
      case (r_rx_state)
        RX_START: r_rx_tcnt <= (r_rx_tcnt == TC_HALF) ? '0 : r_rx_tcnt + 1'b1;
        RX_DATA, RX_PARITY, RX_STOP: begin
          if (r_rx_tcnt == TC_LAST) begin
            r_rx_tcnt <= '0;
            if (r_rx_state == RX_DATA) begin
              r_rx_shift <= {w_rx_s, r_rx_shift[7:1]};
              r_rx_bcnt  <= r_rx_bcnt + 1'b1;
            end
          end else begin
            r_rx_tcnt <= r_rx_tcnt + 1'b1;
          end
        end
        default: begin
          r_rx_tcnt <= '0;
          r_rx_bcnt <= 3'd0;
        end
      endcase
    end
  end

  // RX outputs: FIFO push and flag-set strobes at the end of parity/stop bits
  always_comb begin
    w_rx_bit_end  = w_tick & (r_rx_tcnt == TC_LAST);
    w_rx_push     = 1'b0;
    w_set_overrun = 1'b0;
    w_set_frame   = 1'b0;
    w_set_parity  = 1'b0;
    if (r_rx_state == RX_STOP && w_rx_bit_end) begin
      w_rx_push     = w_rx_s & w_rx_can_push;
      w_set_overrun = w_rx_s & ~w_rx_can_push;
      w_set_frame   = ~w_rx_s;
    end
    if (r_rx_state == RX_PARITY && w_rx_bit_end)
      w_set_parity = (w_rx_s != (^r_rx_shift ^ w_par_odd));
  end

  // TX FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tx_state <= TX_IDLE;
    else        r_tx_state <= w_tx_state_next;
  end

  // TX next state; a waiting byte follows the stop bit with no idle gap.
  always_comb begin
    w_tx_state_next = r_tx_state;
    if (w_tick) begin
      case (r_tx_state)
        TX_IDLE:   if (!w_tx_empty) w_tx_state_next = TX_START;
        TX_START:  if (r_tx_tcnt == TC_LAST) w_tx_state_next = TX_DATA;
        TX_DATA:   if (r_tx_tcnt == TC_LAST && r_tx_bcnt == 3'd7)
                     w_tx_state_next = w_par_en ? TX_PARITY : TX_STOP;
        TX_PARITY: if (r_tx_tcnt == TC_LAST) w_tx_state_next = TX_STOP;
        TX_STOP:   if (r_tx_tcnt == TC_LAST) w_tx_state_next = w_tx_empty ? TX_IDLE : TX_START;
        default:   w_tx_state_next = TX_IDLE;
      endcase
    end
  end

  // TX counters, shifter and parity latch; loaded when a byte is popped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_tcnt  <= '0;
      r_tx_bcnt  <= 3'd0;
      r_tx_shift <= 8'h00;
      r_tx_par   <= 1'b0;
    end else if (w_tick) begin
      if (w_tx_pop) begin
        r_tx_shift <= w_tx_rdata;
        r_tx_par   <= ^w_tx_rdata ^ w_par_odd;
        r_tx_tcnt  <= '0;
        r_tx_bcnt  <= 3'd0;
      end else if (r_tx_state == TX_IDLE) begin
        r_tx_tcnt <= '0;
        r_tx_bcnt <= 3'd0;
      end else if (r_tx_tcnt == TC_LAST) begin
        r_tx_tcnt <= '0;
        if (r_tx_state == TX_DATA) begin
          r_tx_shift <= {1'b0, r_tx_shift[7:1]};
          r_tx_bcnt  <= r_tx_bcnt + 1'b1;
        end
      end else begin
        r_tx_tcnt <= r_tx_tcnt + 1'b1;
      end
    end
  end

  // TX outputs: FIFO pop strobe and line level decoded from state
  always_comb begin
    w_tx_bit_end = w_tick & (r_tx_tcnt == TC_LAST);
    w_tx_pop     = ~w_tx_empty & w_tick &
                   ((r_tx_state == TX_IDLE) | ((r_tx_state == TX_STOP) & w_tx_bit_end));
    case (r_tx_state)
      TX_START:  w_tx = 1'b0;
      TX_DATA:   w_tx = r_tx_shift[0];
      TX_PARITY: w_tx = r_tx_par;
      default:   w_tx = 1'b1;
    endcase
  end

  assign tx = w_tx;
endmodule
